// File: rtl/hazard_stall_controller_pkg.sv
// Shared definitions for the pipeline hazard logic.
// - state_t: sequencer states (RUN / MEM_WAIT / ERROR), fixed encodings.
// - Opcode constants for the decode stage.
// - opcode_uses_rs2(): decode helper that derives IFID_uses_rs2_i.
package hazard_stall_controller_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERROR    = 2'b10
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // R, S and SB formats are the only ones that read rs2.
  function automatic logic opcode_uses_rs2(input logic [6:0] opcode);
    return (opcode == OP_RTYPE) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
  endfunction

endpackage

// File: rtl/hazard_stall_controller_perf_counter.sv
// hazard_perf_counter: free-running event counter.
// - clk_i : clock
// - rst_i : asynchronous reset, active-low, clears the count
// - en_i  : count this cycle
// - cnt_o : current count, wraps modulo 2^CNT_W
module hazard_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_reg <= '0;
    end else if (en_i) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign cnt_o = cnt_reg;

endmodule

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: stall/flush sequencer for the 5-stage pipeline.
// Inputs : clk_i, rst_i (async, active-low), IF/ID register fields
//          (IFID_rs1_i, IFID_rs2_i, IFID_uses_rs2_i), ID/EX load info
//          (IDEX_rd_i, IDEX_MemRead_i), MEM-stage access handshake
//          (EXMEM_MemAccess_i, mem_ready_i), branch_taken_i.
// Outputs: PCWrite_o, IFIDWrite_o, NoOp_o, Flush_o, PipeEn_o pipeline
//          controls; mem_err_o sticky timeout flag; stall_cnt_o and
//          bubble_cnt_o performance counters.
module hazard_stall_controller
  import hazard_stall_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       IFID_rs1_i,
  input  logic [4:0]       IFID_rs2_i,
  input  logic             IFID_uses_rs2_i,
  input  logic [4:0]       IDEX_rd_i,
  input  logic             IDEX_MemRead_i,
  input  logic             EXMEM_MemAccess_i,
  input  logic             mem_ready_i,
  input  logic             branch_taken_i,
  output logic             PCWrite_o,
  output logic             IFIDWrite_o,
  output logic             NoOp_o,
  output logic             Flush_o,
  output logic             PipeEn_o,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_t            state_reg, state_next;
  logic [WAIT_W-1:0] wait_reg, wait_next;
  logic              mem_err_reg, mem_err_next;
  logic              lu, mh, bubble_en;

  assign lu = IDEX_MemRead_i && (IDEX_rd_i != 5'd0) &&
              ((IDEX_rd_i == IFID_rs1_i) ||
               (IFID_uses_rs2_i && (IDEX_rd_i == IFID_rs2_i)));
  assign mh = EXMEM_MemAccess_i && !mem_ready_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg   <= RUN;
      wait_reg    <= '0;
      mem_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      wait_reg    <= wait_next;
      mem_err_reg <= mem_err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    wait_next    = wait_reg;
    mem_err_next = mem_err_reg;
    PCWrite_o    = 1'b0;
    IFIDWrite_o  = 1'b0;
    NoOp_o       = 1'b0;
    Flush_o      = 1'b0;
    PipeEn_o     = 1'b0;
    bubble_en    = 1'b0;
    case (state_reg)
      RUN: begin
        if (mh) begin
          // Memory hold wins over everything: IF/ID and ID/EX are frozen,
          // so any hazard or branch is simply re-evaluated after release.
          state_next = MEM_WAIT;
          wait_next  = WAIT_W'(1);
        end else if (lu) begin
          // Bubble while holding PC and IF/ID; no flush so a dependent
          // branch resolves next cycle with the forwarded load result.
          NoOp_o    = 1'b1;
          PipeEn_o  = 1'b1;
          bubble_en = 1'b1;
        end else begin
          PCWrite_o   = 1'b1;
          IFIDWrite_o = 1'b1;
          PipeEn_o    = 1'b1;
          Flush_o     = branch_taken_i;
        end
      end
      MEM_WAIT: begin
        // The releasing cycle is still frozen; the pipe moves next cycle.
        if (mem_ready_i) begin
          state_next = RUN;
          wait_next  = '0;
        end else if (wait_reg == WAIT_W'(MEM_TIMEOUT - 1)) begin
          state_next   = ERROR;
          mem_err_next = 1'b1;
        end else begin
          wait_next = wait_reg + WAIT_W'(1);
        end
      end
      ERROR: begin
        NoOp_o = 1'b1;
      end
      default: begin
        state_next = RUN;
        wait_next  = '0;
      end
    endcase
  end

  assign mem_err_o = mem_err_reg;

  // Stall cycles are every cycle in which the back end is frozen.
  hazard_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (!PipeEn_o),
    .cnt_o (stall_cnt_o)
  );

  hazard_perf_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (bubble_en),
    .cnt_o (bubble_cnt_o)
  );

endmodule

// File: tb/tb_hazard_stall_controller.sv
module tb_hazard_stall_controller;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 6;
  localparam int CNT_MOD     = 1 << CNT_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [4:0]       rs1 = '0, rs2 = '0, rd = '0;
  logic             uses2 = 1'b0, memread = 1'b0, memacc = 1'b0;
  logic             ready = 1'b1, br = 1'b0;
  logic             pcw, ifidw, noop, flush, pipe, err;
  logic [CNT_W-1:0] stall_c, bubble_c;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: mode 0 = running, 1 = waiting on memory, 2 = timed out.
  int m_mode = 0;
  int m_waited = 0;
  int m_stall = 0;
  int m_bubble = 0;
  bit m_err = 1'b0;

  always #5 clk = ~clk;

  hazard_stall_controller #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk_i             (clk),
    .rst_i             (rst_n),
    .IFID_rs1_i        (rs1),
    .IFID_rs2_i        (rs2),
    .IFID_uses_rs2_i   (uses2),
    .IDEX_rd_i         (rd),
    .IDEX_MemRead_i    (memread),
    .EXMEM_MemAccess_i (memacc),
    .mem_ready_i       (ready),
    .branch_taken_i    (br),
    .PCWrite_o         (pcw),
    .IFIDWrite_o       (ifidw),
    .NoOp_o            (noop),
    .Flush_o           (flush),
    .PipeEn_o          (pipe),
    .mem_err_o         (err),
    .stall_cnt_o       (stall_c),
    .bubble_cnt_o      (bubble_c)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode   = 0;
    m_waited = 0;
    m_stall  = 0;
    m_bubble = 0;
    m_err    = 1'b0;
  endtask

  // One clock cycle: check outputs mid-cycle against the model, then
  // advance the model with the same inputs and cross the rising edge.
  task automatic step();
    bit lu, mh;
    bit e_pc, e_ifid, e_noop, e_flush, e_pipe;
    #4;
    if (!rst_n) model_reset();
    lu = memread && (rd != 0) && ((rd == rs1) || (uses2 && (rd == rs2)));
    mh = memacc && !ready;
    e_pc = 0; e_ifid = 0; e_noop = 0; e_flush = 0; e_pipe = 0;
    if (m_mode == 2) begin
      e_noop = 1;
    end else if (m_mode == 1 || mh) begin
      // everything frozen
    end else if (lu) begin
      e_noop = 1;
      e_pipe = 1;
    end else begin
      e_pc = 1; e_ifid = 1; e_pipe = 1; e_flush = br;
    end
    check_val("PCWrite", pcw, e_pc);
    check_val("IFIDWrite", ifidw, e_ifid);
    check_val("NoOp", noop, e_noop);
    check_val("Flush", flush, e_flush);
    check_val("PipeEn", pipe, e_pipe);
    check_val("mem_err", err, m_err);
    check_val("stall_cnt", stall_c, m_stall);
    check_val("bubble_cnt", bubble_c, m_bubble);
    if (rst_n) begin
      if (!e_pipe) m_stall = (m_stall + 1) % CNT_MOD;
      if (m_mode == 0 && !mh && lu) m_bubble = (m_bubble + 1) % CNT_MOD;
      if (m_mode == 0) begin
        if (mh) begin m_mode = 1; m_waited = 1; end
      end else if (m_mode == 1) begin
        if (ready) begin
          m_mode = 0; m_waited = 0;
        end else if (m_waited == MEM_TIMEOUT - 1) begin
          m_mode = 2; m_err = 1'b1;
        end else begin
          m_waited++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rs1 = 0; rs2 = 0; rd = 0; uses2 = 0; memread = 0;
    memacc = 0; ready = 1; br = 0;
  endtask

  initial begin
    int base;
    idle_inputs();
    rst_n = 0;
    step();
    check_val("reset_stall", stall_c, 0);
    check_val("reset_bubble", bubble_c, 0);
    rst_n = 1;
    step();

    // lw x5 in ID/EX, add x6,x5,x1 in IF/ID
    $display("txn: load-use add x6,x5,x1");
    rd = 5; memread = 1; rs1 = 5; rs2 = 1; uses2 = 1;
    step();
    check_val("lu_bubble_inc", bubble_c, 1);
    memread = 0; rd = 0;
    step();

    $display("txn: load to x0, reader of x0");
    rd = 0; memread = 1; rs1 = 0; rs2 = 0; uses2 = 1;
    step();
    check_val("x0_no_bubble", bubble_c, 1);

    $display("txn: store with rs2 matching load rd");
    rd = 7; memread = 1; rs1 = 2; rs2 = 7; uses2 = 1;
    step();
    check_val("store_bubble", bubble_c, 2);
    uses2 = 0;
    step();
    idle_inputs();
    step();

    $display("txn: memory hold 3 cycles then ready");
    base = m_stall;
    memacc = 1; ready = 0;
    repeat (3) step();
    ready = 1;
    step();
    memacc = 0;
    step();
    check_val("hold_stall_plus4", stall_c, (base + 4) % CNT_MOD);

    $display("txn: branch during memory hold");
    memacc = 1; ready = 0; br = 1;
    step();
    ready = 1;
    step();
    memacc = 0;
    step();
    br = 0;
    step();

    $display("txn: memory timeout");
    memacc = 1; ready = 0;
    repeat (4) step();
    check_val("timeout_err", err, 1);
    repeat (3) step();
    rst_n = 0;
    step();
    check_val("err_cleared", err, 0);
    rst_n = 1;
    idle_inputs();
    step();

    $display("txn: counter wrap via repeated holds");
    repeat (24) begin
      memacc = 1; ready = 0;
      repeat (2) step();
      ready = 1;
      step();
      memacc = 0;
      step();
    end

    $display("txn: randomized traffic");
    for (int i = 0; i < 1500; i++) begin
      rst_n   = ($urandom_range(0, 99) >= 2);
      rd      = 5'($urandom_range(0, 3));
      rs1     = 5'($urandom_range(0, 3));
      rs2     = 5'($urandom_range(0, 3));
      uses2   = 1'($urandom_range(0, 1));
      memread = 1'($urandom_range(0, 1));
      memacc  = ($urandom_range(0, 9) < 4);
      ready   = ($urandom_range(0, 9) < 6);
      br      = 1'($urandom_range(0, 1));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Detects load-use hazards and drives NoOp_i into the Control unit.
- Freezes the whole pipeline while the data memory holds off a MEM-stage access, and flushes IF/ID on taken branches.
- Keeps performance counters of stall and bubble cycles.

Parameters:
- MEM_TIMEOUT, 64: max consecutive wait cycles on one memory access before a fatal error.
- CNT_W, 32: width of the performance counters.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-low.
- IFID_rs1_i  in  5  rs1 field of the instruction in IF/ID.
- IFID_rs2_i  in  5  rs2 field of the instruction in IF/ID.
- IFID_uses_rs2_i  in  1  instruction in IF/ID reads rs2 (R, S, SB types).
- IDEX_rd_i  in  5  rd of the instruction in ID/EX.
- IDEX_MemRead_i  in  1  instruction in ID/EX is a load.
- EXMEM_MemAccess_i  in  1  instruction in EX/MEM is a load or store.
- mem_ready_i  in  1  data memory completes the current access this cycle.
- branch_taken_i  in  1  ID-stage branch resolved as taken.
- PCWrite_o  out  1  PC update enable.
- IFIDWrite_o  out  1  IF/ID register enable.
- NoOp_o  out  1  forces Control outputs to a bubble.
- Flush_o  out  1  clears IF/ID to NOP.
- PipeEn_o  out  1  enable for ID/EX, EX/MEM and MEM/WB.
- mem_err_o  out  1  sticky memory timeout flag.
- stall_cnt_o  out  CNT_W  total cycles with PipeEn_o=0.
- bubble_cnt_o  out  CNT_W  total load-use bubbles inserted.

Behaviour:
- States:
  - RUN.
  - MEM_WAIT.
  - ERROR.
- Reset (async, rst_i=0) sets:
  - state=RUN, wait counter=0, mem_err_o=0, stall_cnt_o=0, bubble_cnt_o=0.
  - The combinational outputs then evaluate from RUN with current inputs.
- Load-use hazard term (lu): IDEX_MemRead_i & IDEX_rd_i!=0 & (IDEX_rd_i==IFID_rs1_i | (IFID_uses_rs2_i & IDEX_rd_i==IFID_rs2_i)).
- Memory hold term (mh): EXMEM_MemAccess_i & ~mem_ready_i.
- RUN, mh=1:
  - PipeEn_o=PCWrite_o=IFIDWrite_o=0, NoOp_o=0, Flush_o=0.
  - Next state MEM_WAIT; wait counter loads 1.
- RUN, mh=0, lu=1:
  - PCWrite_o=0, IFIDWrite_o=0, NoOp_o=1, PipeEn_o=1, Flush_o=0.
  - Exactly one bubble is inserted; bubble_cnt_o+1.
- RUN, mh=0, lu=0:
  - All enables 1, NoOp_o=0.
  - Flush_o=branch_taken_i.
- MEM_WAIT:
  - All enables 0, NoOp_o=0, Flush_o=0, stall_cnt_o+1 every cycle in this state.
  - mem_ready_i=1: enables still 0 this cycle; next state RUN; wait counter clears.
  - mem_ready_i=0 and wait counter==MEM_TIMEOUT-1: next state ERROR, mem_err_o<=1.
  - Otherwise: wait counter+1.
- The RUN cycle that entered MEM_WAIT also counts in stall_cnt_o. The access therefore stalls for N+1 cycles when ready arrives N cycles after entry.
- ERROR:
  - All enables 0, NoOp_o=1.
  - Held until reset; mem_err_o stays 1.
- Priority: mh > lu > branch.
  - A branch or load-use condition coinciding with mh is ignored in that cycle and re-evaluated after release, because IF/ID and ID/EX are frozen.
  - Flush_o is never asserted in the same cycle as lu=1. The branch reading the load result waits one bubble and then resolves with the correct operand.
- A single-cycle hit (EXMEM_MemAccess_i=1 & mem_ready_i=1 in RUN) causes no stall.
- Counters wrap modulo 2^CNT_W and never saturate.
- Reset asserted mid-MEM_WAIT or in ERROR returns to RUN immediately (asynchronous).

Decomposition:
- Shared package (same header used by the Control unit's ALUOp defines):
  - State encodings: RUN=2'b00, MEM_WAIT=2'b01, ERROR=2'b10.
  - Opcode constants used by the decode stage to derive IFID_uses_rs2_i.
- One natural sub-module: hazard_perf_counter, an enable-driven CNT_W-bit wrapping counter with async active-low reset, instantiated twice.

Test Plan:
- lw x5,0(x0) in ID/EX with add x6,x5,x1 in IF/ID, mem_ready_i=1 -> one cycle with NoOp_o=1, PCWrite_o=0, IFIDWrite_o=0; bubble_cnt_o 0->1; next cycle all enables 1.
- Load to x0 with a following instruction reading x0 -> no bubble; store with rs2 matching the load rd and IFID_uses_rs2_i=1 -> bubble.
- EXMEM_MemAccess_i=1, mem_ready_i low for 3 cycles then high -> PipeEn_o=0 for 4 cycles; stall_cnt_o +4; state back to RUN.
- mem_ready_i held low with MEM_TIMEOUT=4 -> mem_err_o rises on the 4th stall cycle; all enables stay 0 and NoOp_o=1; rst_i pulse low clears to RUN with counters 0.
- branch_taken_i=1 together with mh=1 -> Flush_o=0 while stalled; Flush_o=1 on the first RUN cycle after release while branch_taken_i is still 1.
- Preload stall_cnt_o to 2^CNT_W-1 by forcing, then one more stall cycle -> wraps to 0.
